y86_writeback_rf: RTL

Y86_WRITEBACK_RF -- requirements
Module: y86_writeback_rf

---
 rtl/y86_pkg.sv | 34 +++
 rtl/y86_writeback_rf_if.sv | 32 +++
 rtl/y86_dst_decode.sv | 29 ++
 rtl/y86_writeback_rf.sv | 91 +++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86 definitions for the writeback / register-file slice:
// instruction codes, register specifiers and the decoded destination pair.
package y86_pkg;

    localparam int unsigned REG_ID_W = 4;
    localparam int unsigned CNT_W    = 16;

    localparam logic [3:0] HALT   = 4'h0;
    localparam logic [3:0] NOP    = 4'h1;
    localparam logic [3:0] CMOVXX = 4'h2;
    localparam logic [3:0] IRMOVQ = 4'h3;
    localparam logic [3:0] RMMOVQ = 4'h4;
    localparam logic [3:0] MRMOVQ = 4'h5;
    localparam logic [3:0] OPQ    = 4'h6;
    localparam logic [3:0] JXX    = 4'h7;
    localparam logic [3:0] CALL   = 4'h8;
    localparam logic [3:0] RET    = 4'h9;
    localparam logic [3:0] PUSHQ  = 4'hA;
    localparam logic [3:0] POPQ   = 4'hB;

    localparam logic [3:0] RNONE  = 4'hF;
    localparam logic [3:0] RSP    = 4'h4;

    typedef struct packed {
        logic [REG_ID_W-1:0] dst_e;
        logic [REG_ID_W-1:0] dst_m;
    } dst_t;

    // Codes above POPQ are not part of the instruction set.
    function automatic logic icode_invalid(input logic [3:0] ic);
        return ic > POPQ;
    endfunction

endpackage

// File: rtl/y86_writeback_rf_if.sv
// Writeback request, read ports and status of the Y86 register file.
interface y86_writeback_rf_if
    import y86_pkg::*;
#(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned NREGS  = 15
);
    logic                    wb_valid;
    logic [3:0]              icode;
    logic                    cond;
    logic [REG_ID_W-1:0]     rA;
    logic [REG_ID_W-1:0]     rB;
    logic [DATA_W-1:0]       valE;
    logic [DATA_W-1:0]       valM;
    logic [REG_ID_W-1:0]     srcA;
    logic [REG_ID_W-1:0]     srcB;
    logic [DATA_W-1:0]       valA;
    logic [DATA_W-1:0]       valB;
    logic [NREGS*DATA_W-1:0] reg_flat;
    logic [CNT_W-1:0]        wr_count;
    logic                    bad_icode;

    modport master (
        output wb_valid, icode, cond, rA, rB, valE, valM, srcA, srcB,
        input  valA, valB, reg_flat, wr_count, bad_icode
    );

    modport slave (
        input  wb_valid, icode, cond, rA, rB, valE, valM, srcA, srcB,
        output valA, valB, reg_flat, wr_count, bad_icode
    );
endinterface

// File: rtl/y86_dst_decode.sv
// Maps an instruction's icode/cond/rA/rB to its E and M write destinations.
module y86_dst_decode
    import y86_pkg::*;
(
    input  logic [3:0]          icode,
    input  logic                cond,
    input  logic [REG_ID_W-1:0] rA,
    input  logic [REG_ID_W-1:0] rB,
    output dst_t                dst_c
);

    always_comb begin
        dst_c.dst_e = RNONE;
        dst_c.dst_m = RNONE;
        case (icode)
            CMOVXX:            if (cond) dst_c.dst_e = rB;
            IRMOVQ, OPQ:       dst_c.dst_e = rB;
            CALL, RET, PUSHQ:  dst_c.dst_e = RSP;
            MRMOVQ:            dst_c.dst_m = rA;
            POPQ: begin
                dst_c.dst_e = RSP;
                dst_c.dst_m = rA;
            end
            HALT, NOP, RMMOVQ, JXX: ;
            default: ;
        endcase
    end

endmodule

// File: rtl/y86_writeback_rf.sv
// Y86 register file with dual writeback (valE/valM), combinational read ports
// with optional same-cycle bypass, a commit counter and a sticky bad-icode flag.
module y86_writeback_rf
    import y86_pkg::*;
#(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned NREGS  = 15,
    parameter int unsigned BYPASS = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    y86_writeback_rf_if.slave bus
);

    dst_t dst_c;

    y86_dst_decode u_dst_decode (
        .icode (bus.icode),
        .cond  (bus.cond),
        .rA    (bus.rA),
        .rB    (bus.rB),
        .dst_c (dst_c)
    );

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic [CNT_W-1:0]  wr_count_q, wr_count_d;
    logic              bad_icode_q, bad_icode_d;
    logic              wr_e_c, wr_m_c;

    // Specifiers at or above NREGS (including RNONE) never write.
    always_comb begin
        wr_e_c = bus.wb_valid && (32'(dst_c.dst_e) < NREGS);
        wr_m_c = bus.wb_valid && (32'(dst_c.dst_m) < NREGS);
    end

    // M is applied after E so popq %rsp keeps the loaded value.
    always_comb begin
        for (int i = 0; i < int'(NREGS); i++) begin
            regs_d[i] = regs_q[i];
            if (wr_e_c && dst_c.dst_e == REG_ID_W'(i)) regs_d[i] = bus.valE;
            if (wr_m_c && dst_c.dst_m == REG_ID_W'(i)) regs_d[i] = bus.valM;
        end
        wr_count_d  = (wr_e_c || wr_m_c) ? wr_count_q + CNT_W'(1) : wr_count_q;
        bad_icode_d = bad_icode_q | (bus.wb_valid & icode_invalid(bus.icode));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREGS); i++) regs_q[i] <= '0;
            wr_count_q  <= '0;
            bad_icode_q <= 1'b0;
        end else begin
            for (int i = 0; i < int'(NREGS); i++) regs_q[i] <= regs_d[i];
            wr_count_q  <= wr_count_d;
            bad_icode_q <= bad_icode_d;
        end
    end

    // Read ports: out-of-range addresses return 0; bypass mirrors write priority.
    always_comb begin
        bus.valA = '0;
        bus.valB = '0;
        for (int i = 0; i < int'(NREGS); i++) begin
            if (bus.srcA == REG_ID_W'(i)) begin
                bus.valA = regs_q[i];
                if (BYPASS != 0) begin
                    if (wr_e_c && dst_c.dst_e == REG_ID_W'(i)) bus.valA = bus.valE;
                    if (wr_m_c && dst_c.dst_m == REG_ID_W'(i)) bus.valA = bus.valM;
                end
            end
            if (bus.srcB == REG_ID_W'(i)) begin
                bus.valB = regs_q[i];
                if (BYPASS != 0) begin
                    if (wr_e_c && dst_c.dst_e == REG_ID_W'(i)) bus.valB = bus.valE;
                    if (wr_m_c && dst_c.dst_m == REG_ID_W'(i)) bus.valB = bus.valM;
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < int'(NREGS); i++) begin
            bus.reg_flat[i*DATA_W +: DATA_W] = regs_q[i];
        end
    end

    assign bus.wr_count  = wr_count_q;
    assign bus.bad_icode = bad_icode_q;

endmodule
